// File: rtl/fetch_stage.sv
// RV32 instruction fetch: owns the PC, issues in-order word reads, buffers
// responses for the decoder and squashes stale fetches on execute redirects.
module fetch_stage #(
  parameter int          INSTRUCTON_WIDTH = 32,
  parameter logic [31:0] RESET_PC         = 32'h0000_0000,
  parameter int          FIFO_DEPTH       = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        imem_req_valid,
  input  logic                        imem_req_ready,
  output logic [31:0]                 imem_addr,
  input  logic                        imem_rsp_valid,
  input  logic [INSTRUCTON_WIDTH-1:0] imem_rsp_data,
  input  logic                        redirect_valid,
  input  logic [31:0]                 redirect_pc,
  output logic                        instr_valid,
  input  logic                        instr_ready,
  output logic [INSTRUCTON_WIDTH-1:0] instruction,
  output logic [31:0]                 instr_pc
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] FULL_W  = CW'(FIFO_DEPTH);

  logic [31:0]                 pc;
  logic [CW-1:0]               inflight;
  logic [CW-1:0]               drop;
  logic [CW-1:0]               count;
  logic [CW-1:0]               inflight_next;
  logic [CW:0]                 occupancy;
  logic [AW-1:0]               pq_wr;
  logic [AW-1:0]               pq_rd;
  logic [AW-1:0]               fq_wr;
  logic [AW-1:0]               fq_rd;
  logic [31:0]                 pq_pc   [FIFO_DEPTH];
  logic [INSTRUCTON_WIDTH-1:0] fq_data [FIFO_DEPTH];
  logic [31:0]                 fq_pc   [FIFO_DEPTH];
  logic                        accept;
  logic                        push;
  logic                        pop;

  // Credit: every in-flight request already owns a future buffer slot.
  assign occupancy      = {1'b0, inflight} + {1'b0, count};
  assign imem_req_valid = !rst && !redirect_valid && (occupancy < DEPTH_W);
  assign imem_addr      = pc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign push           = imem_rsp_valid && !redirect_valid && (drop == '0);
  assign pop            = instr_valid && instr_ready;
  assign inflight_next  = inflight + CW'(accept) - CW'(imem_rsp_valid);

  assign instr_valid = (count != '0);
  assign instruction = instr_valid ? fq_data[fq_rd] : '0;
  assign instr_pc    = instr_valid ? fq_pc[fq_rd] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
      count    <= '0;
      pq_wr    <= '0;
      pq_rd    <= '0;
      fq_wr    <= '0;
      fq_rd    <= '0;
    end else begin
      inflight <= inflight_next;
      if (accept) begin
        pc    <= pc + 32'd4;
        pq_wr <= pq_wr + AW'(1);
      end
      // The PC queue advances on every response, kept or dropped.
      if (imem_rsp_valid) pq_rd <= pq_rd + AW'(1);
      if (redirect_valid) begin
        pc    <= {redirect_pc[31:2], 2'b00};
        drop  <= inflight_next;
        count <= '0;
        fq_wr <= '0;
        fq_rd <= '0;
      end else begin
        if (imem_rsp_valid && (drop != '0)) drop <= drop - CW'(1);
        if (push) fq_wr <= fq_wr + AW'(1);
        if (pop)  fq_rd <= fq_rd + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) pq_pc[pq_wr] <= pc;
    if (push) begin
      fq_data[fq_wr] <= imem_rsp_data;
      fq_pc[fq_wr]   <= pq_pc[pq_rd];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && (count == FULL_W)));
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: queue-level reference model plus directed and
// randomized memory/decoder/redirect stimulus, with literal anchor checks.
module tb_fetch_stage;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic        redirect_valid, instr_valid, instr_ready;
  logic [31:0] imem_addr, imem_rsp_data, redirect_pc, instruction, instr_pc;

  logic        rst2, req_valid2, rsp_valid2, instr_valid2;
  logic [31:0] addr2, instruction2, instr_pc2;

  always #5 clk = ~clk;

  fetch_stage #(.INSTRUCTON_WIDTH(32), .RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .instr_pc(instr_pc)
  );

  fetch_stage #(.INSTRUCTON_WIDTH(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut2 (
    .clk(clk), .rst(rst2),
    .imem_req_valid(req_valid2), .imem_req_ready(1'b1), .imem_addr(addr2),
    .imem_rsp_valid(rsp_valid2), .imem_rsp_data(32'h0),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .instr_valid(instr_valid2), .instr_ready(1'b1),
    .instruction(instruction2), .instr_pc(instr_pc2)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        memq[$];
  logic [31:0] fifo_m[$];
  int          inflight_m, drop_m, cyc, last_due, tests, fails, lat_min, lat_max;
  logic [31:0] pc_m, deliver_pc, prev_addr;
  logic        prev_stall, arm, hit;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // One clock: drive at negedge, check at negedge+1, advance the model to the next edge.
  task automatic step(input logic r, input logic rr, input logic ir, input logic rd,
                      input logic [31:0] rpc);
    logic        rsp, rd_eff, exp_rv, acc, pop;
    logic [31:0] head;
    req_t        m;
    int          due;
    @(negedge clk);
    rsp    = !r && (memq.size() > 0) && (memq[0].due <= cyc);
    rd_eff = rd;
    if (arm && !r && rsp && (fifo_m.size() > 0) && ir) begin
      rd_eff = 1'b1;
      arm    = 1'b0;
      hit    = 1'b1;
    end
    rst            = r;
    imem_req_ready = rr;
    instr_ready    = ir;
    redirect_valid = rd_eff;
    redirect_pc    = rpc;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? imem_word(memq[0].addr) : $urandom;
    #1;
    if (r) begin
      chk("req_valid_in_reset", 32'(imem_req_valid), 32'd0);
      pc_m = RPC; deliver_pc = RPC;
      inflight_m = 0; drop_m = 0; last_due = 0;
      fifo_m.delete(); memq.delete();
      prev_stall = 1'b0;
    end else begin
      exp_rv = !rd_eff && ((inflight_m + fifo_m.size()) < DEPTH);
      head   = (fifo_m.size() > 0) ? fifo_m[0] : 32'h0;
      chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      chk("imem_addr", imem_addr, pc_m);
      chk("instr_valid", 32'(instr_valid), 32'(fifo_m.size() > 0));
      chk("instr_pc", instr_pc, head);
      chk("instruction", instruction, (fifo_m.size() > 0) ? imem_word(head) : 32'h0);
      if (prev_stall) chk("addr_hold", imem_addr, prev_addr);
      if (instr_valid && ir) begin
        chk("deliver_seq", instr_pc, deliver_pc);
        deliver_pc = deliver_pc + 32'd4;
      end
      acc        = exp_rv && rr;
      pop        = (fifo_m.size() > 0) && ir;
      prev_stall = exp_rv && !rr;
      prev_addr  = imem_addr;
      if (pop) void'(fifo_m.pop_front());
      if (rsp) begin
        m = memq.pop_front();
        inflight_m--;
        if (rd_eff) ;
        else if (drop_m > 0) drop_m--;
        else fifo_m.push_back(m.addr);
      end
      if (acc) begin
        due = cyc + 1 + $urandom_range(lat_max, lat_min);
        if (due < last_due) due = last_due;
        last_due = due;
        memq.push_back('{addr: pc_m, due: due});
        inflight_m++;
        pc_m = pc_m + 32'd4;
      end
      if (rd_eff) begin
        fifo_m.delete();
        drop_m     = inflight_m;
        pc_m       = {rpc[31:2], 2'b00};
        deliver_pc = {rpc[31:2], 2'b00};
        prev_stall = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic wrap_test();
    logic [31:0] got [3];
    int          n;
    logic        acc_last, seen;
    logic [31:0] first_pc;
    n = 0; acc_last = 1'b0; seen = 1'b0; first_pc = 32'h0;
    for (int i = 0; i < 3; i++) got[i] = 32'h0;
    @(negedge clk); rst2 = 1'b1; rsp_valid2 = 1'b0;
    for (int k = 0; k < 20 && n < 3; k++) begin
      @(negedge clk);
      rst2 = 1'b0; rsp_valid2 = acc_last;
      #1;
      acc_last = req_valid2;
      if (req_valid2) begin got[n] = addr2; n++; end
      if (instr_valid2 && !seen) begin seen = 1'b1; first_pc = instr_pc2; end
    end
    chk("wrap_count", 32'(n), 32'd3);
    chk("wrap_addr0", got[0], 32'hFFFF_FFF8);
    chk("wrap_addr1", got[1], 32'hFFFF_FFFC);
    chk("wrap_addr2", got[2], 32'h0000_0000);
    chk("wrap_first_instr_pc", first_pc, 32'hFFFF_FFF8);
  endtask

  initial begin
    logic found;
    tests = 0; fails = 0; cyc = 0; arm = 1'b0; hit = 1'b0;
    lat_min = 0; lat_max = 0; prev_stall = 1'b0; prev_addr = 32'h0;
    pc_m = RPC; deliver_pc = RPC; inflight_m = 0; drop_m = 0; last_due = 0;
    rst = 1'b1; imem_req_ready = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    rst2 = 1'b1; rsp_valid2 = 1'b0;

    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_instruction", instruction, 32'h0);
    chk("first_addr", imem_addr, 32'h0);
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("second_addr", imem_addr, 32'h4);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("lat2_valid", 32'(instr_valid), 32'd1);
    chk("lat2_pc", instr_pc, 32'h0);
    chk("lat2_word", instruction, 32'h1357_6420);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("lat3_pc", instr_pc, 32'h4);
    repeat (12) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

    repeat (10) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    chk("stall_instr_valid", 32'(instr_valid), 32'd1);
    repeat (10) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

    lat_min = 3; lat_max = 3; found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      if (inflight_m == 2) found = 1'b1;
    end
    chk("reach_two_inflight", 32'(found), 32'd1);
    lat_min = 0; lat_max = 0;
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0103);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("redir_next_addr", imem_addr, 32'h0000_0100);
    chk("redir_next_ivalid", 32'(instr_valid), 32'd0);
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      if (instr_valid) found = 1'b1;
    end
    chk("redir_first_found", 32'(found), 32'd1);
    chk("redir_first_pc", instr_pc, 32'h0000_0100);

    arm = 1'b1; hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0200);
    arm = 1'b0;
    chk("same_cycle_redir_hit", 32'(hit), 32'd1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("same_cycle_ivalid", 32'(instr_valid), 32'd0);
    chk("same_cycle_addr", imem_addr, 32'h0000_0200);

    lat_min = 0; lat_max = 3;
    for (int i = 0; i < 400; i++)
      step(i == 200, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 29) == 0, $urandom);

    wrap_test();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- RV32 instruction fetch stage. Sits directly upstream of the instruction decoder and feeds it one 32-bit instruction word per handshake.
- Owns the PC and issues in-order word reads to instruction memory over a valid/ready request channel.
- Buffers responses in a small FIFO and applies redirects from execute (branch/jump/trap), discarding stale in-flight fetches.

Parameters:
INSTRUCTON_WIDTH, 32, instruction word width; only 32 is supported.
RESET_PC, 32'h0000_0000, PC value loaded on reset.
FIFO_DEPTH, 2, instruction buffer depth (power of two, >=2); also the cap on in-flight plus buffered fetches.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_addr  output  32  word-aligned fetch address
imem_rsp_valid  input  1  read data valid; in order, at least 1 cycle after acceptance
imem_rsp_data  input  INSTRUCTON_WIDTH  read data
redirect_valid  input  1  PC redirect pulse from execute
redirect_pc  input  32  redirect target
instr_valid  output  1  instruction available to decoder
instr_ready  input  1  decoder consumes instruction
instruction  output  INSTRUCTON_WIDTH  to decoder input_instruction
instr_pc  output  32  PC of the presented instruction

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on rst.
- Reset (rst=1 at an edge), takes precedence over everything:
  - pc=RESET_PC
  - FIFO empty; inflight=0; drop=0
  - imem_req_valid=0, instr_valid=0, instruction=0, instr_pc=0
  - rst asserted mid-operation abandons all in-flight requests. Responses arriving after reset are not guarded; memory must be reset together with this block.
- Request issue:
  - imem_req_valid=1 iff !rst && !redirect_valid && (inflight + fifo_count) < FIFO_DEPTH.
  - imem_addr=pc, combinational from the pc register.
  - On accept (valid&&ready): pc<=pc+4 with 32-bit wrap, so 0xFFFF_FFFC -> 0x0000_0000. inflight increments.
  - The first request is issued in the cycle after rst deasserts.
- Response:
  - Each imem_rsp_valid decrements inflight.
  - If drop>0: the response is discarded and drop decrements.
  - Otherwise {imem_rsp_data, its PC} is pushed into the FIFO. The PC comes from a parallel PC queue filled at request accept.
  - A credit rule guarantees no overflow; a push into a full FIFO is a design error (assert).
- Output:
  - instr_valid = FIFO not empty. instruction/instr_pc = head entry; zero when empty.
  - Pop on instr_valid&&instr_ready. Push and pop in the same cycle are both allowed.
  - Minimum latency: request accepted at cycle N, response at N+1, instr_valid at N+2 (no bypass).
  - instr_valid, once high, stays high with stable data until consumed or redirected.
- Redirect (redirect_valid=1 in cycle R):
  - pc<=redirect_pc with bits [1:0] forced to 0.
  - FIFO flushed at the end of R. instr_valid=0 in R+1 unless a new response arrives; it cannot, so instr_valid=0 in R+1.
  - drop <= number of in-flight requests not yet answered after cycle R, i.e. inflight after R's updates.
  - A response in cycle R is discarded.
  - imem_req_valid is forced 0 in R, so no request is accepted in R. The first request to the target is issued in R+1.
  - A decoder handshake in cycle R still completes; the consumed instruction is the decoder's responsibility to squash.
  - Back-to-back redirects: the last one wins; the drop count is recomputed each time.
- Counters:
  - inflight and drop are sized clog2(FIFO_DEPTH)+1 bits.
  - inflight+fifo_count never exceeds FIFO_DEPTH.

Test Plan:
- Reset then free-run (imem 1-cycle latency, instr_ready=1) -> imem_addr 0,4,8,...; instr_pc 0 at cycle 2 after reset release; one instruction per cycle.
- Decoder stall (instr_ready=0 for 10 cycles) -> FIFO fills with 2 entries; imem_req_valid drops to 0; no overflow. On release, PCs are delivered in order with no gap or duplicate.
- Redirect with 2 requests in flight, redirect_pc=0x103 -> both responses dropped; next imem_addr=0x100; next instr_pc=0x100.
- Redirect in the same cycle as imem_rsp_valid and instr_valid&&instr_ready -> the response is not delivered; the head is popped; instr_valid=0 the next cycle.
- RESET_PC=32'hFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
- imem_req_ready randomly toggled plus variable response latency -> imem_addr is stable while valid&&!ready; delivered PC sequence is strictly +4 between redirects.
